uart_rx_responder: RTL and testbench
====================================

# uart_rx_responder

Receive side of the CPU's UART read port. Deserializes the 8N1 serial input line, buffers received bytes in a small FIFO, and answers the CPU's `uartReadReq` level request with a one-cycle `uartReadAck` plus `uartReadData`. It sits at the board level between the RX pin and the CPU, mirroring the transmit path that serves `uartWriteReq`.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, 16, receive FIFO entries; power of two, ≥ 2.
- `clk`  input  1  system clock, all logic on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `uartRx`  input  1  serial line; idles high; asynchronous to `clk`.
- `uartReadReq`  input  1  CPU read request, level; held until ack.
- `uartReadAck`  output  1  one-cycle pulse; `uartReadData` is valid in that cycle.
- `uartReadData`  output  8  byte popped from FIFO.
- `fifoCount`  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overrun`  output  1  sticky; a byte was dropped because the FIFO was full.
- `framingErr`  output  1  one-cycle pulse on a bad stop bit.
- `parityErr`  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

## Operation
- `uartRx` passes through a 2-flop synchronizer that resets to 1. All sampling uses the synchronized value.
- Receiver FSM states: IDLE, START, DATA, [PARITY], STOP, WAITHI. A bit counter runs 0..CLKS_PER_BIT-1.
- IDLE: on a low line, go to START and load the counter for half a bit.
- START: at mid-bit, a low line goes to DATA. A high line is a glitch; return to IDLE with no flags.
- DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into the shift register. Then go to PARITY if built, otherwise STOP.
- STOP: sample at mid-bit.
  - 1: push the byte and return to IDLE.
  - 0: pulse `framingErr`, discard the byte, go to WAITHI.
- WAITHI: stay until the line reads high, then go to IDLE. This stops a break condition from re-triggering.
- Push when full: byte dropped, `overrun` set. `overrun` clears only on reset.
- Read handshake:
  - When `uartReadReq`=1, FIFO non-empty and responder armed, assert `uartReadAck` for exactly one cycle with the head byte, and pop.
  - The responder then disarms and re-arms only after seeing `uartReadReq`=0 for at least one cycle. One request yields exactly one byte.
  - With an empty FIFO, the request waits; ack follows the first push.
- Push and pop in the same cycle both take effect; `fifoCount` is unchanged. A push into a full FIFO with a simultaneous pop succeeds.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. `fifoCount` saturates at FIFO_DEPTH by construction.
- Reset values: `uartReadAck`=0, `uartReadData`=0, `fifoCount`=0, `overrun`=0, `framingErr`=0, `parityErr`=0. FSM goes to IDLE, armed.
- Reset mid-frame abandons the partial byte. After release, reception resumes at the next start bit seen from IDLE.

## Timing
- Synchronizer delay: 2 cycles.
- Start-bit mid-sample falls CLKS_PER_BIT/2 (integer division) cycles after the low is seen.
- Push happens in the cycle after the stop-bit sample. `fifoCount` updates the following cycle.
- Ack latency: registered, 1 cycle after request, non-empty and armed all hold.
- Minimum spacing between two acks: 3 cycles (ack, req low, req high, ack).
- `framingErr` and `parityErr` pulse in the cycle after their sample point.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state samples one even-parity bit after the 8 data bits.
  - On mismatch: pulse `parityErr`, discard the byte, still check the stop bit, return to IDLE or WAITHI as usual.
- Undefined: no PARITY state; frame is 8N1; `parityErr` tied 0.

## Test plan
- CLKS_PER_BIT=16: send 0xA5 at 8N1, `uartReadReq` high → one ack, data 0xA5, `fifoCount` 1→0, no flags.
- Send 0x01, 0x80, 0xFF back-to-back with the request held low → `fifoCount`=3. Three req/ack cycles return 0x01, 0x80, 0xFF in order. Holding req high across two cycles yields only one ack.
- FIFO_DEPTH=4: send 5 bytes with no reads → `fifoCount`=4, `overrun`=1; reads return the first 4 bytes.
- Low glitch of 4 cycles on `uartRx` → no push, no flags. Frame 0x3C with stop bit 0, then line held low 50 cycles → one `framingErr` pulse, no push; next valid 0x11 is received.
- Assert `reset` during bit 4 of a frame → all outputs at reset values. Next full frame 0x5A is received correctly.
- With `UART_RX_PARITY_EN`: 0x07 with parity 1 → accepted. 0x07 with parity 0 → `parityErr` pulse, no push.

Source files
------------

// File: rtl/uart_rx_responder.sv
// UART receiver with a small FIFO that answers a level-request / one-cycle-ack CPU read port.
// Define UART_RX_PARITY_EN to receive 8E1 frames; the default build receives 8N1.
module uart_rx_responder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uartRx,
  input  logic                          uartReadReq,
  output logic                          uartReadAck,
  output logic [7:0]                    uartReadData,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          overrun,
  output logic                          framingErr,
  output logic                          parityErr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAITHI
  } state_t;

  logic          sync1_q, sync2_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          framing_q, framing_d;
  logic          parity_err_q, parity_err_d;
  logic          par_bad_q, par_bad_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          armed_q, armed_d;
  logic          ack_q, ack_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          overrun_q, overrun_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic          rx_s;
  logic          pop;
  logic          full;
  logic          wr_en;

  assign rx_s = sync2_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    push_d       = 1'b0;
    framing_d    = 1'b0;
    parity_err_d = 1'b0;
    par_bad_d    = par_bad_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
            par_bad_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        // Even parity: the parity bit XOR all data bits must be zero.
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          state_d      = STOP;
          par_bad_d    = rx_s ^ (^shift_q);
          parity_err_d = rx_s ^ (^shift_q);
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            push_d  = !par_bad_q;
            state_d = IDLE;
          end else begin
            framing_d = 1'b1;
            state_d   = WAITHI;
          end
        end
      end
      WAITHI: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // A push into a full FIFO is still accepted when a pop frees the slot in the same cycle.
  always_comb begin
    pop       = uartReadReq && (count_q != '0) && armed_q;
    full      = (count_q == FULL_CNT);
    wr_en     = push_q && (!full || pop);
    wr_ptr_d  = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (wr_en && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (!wr_en && pop) count_d = count_q - (AW + 1)'(1);
    overrun_d = overrun_q | (push_q && full && !pop);
    armed_d   = armed_q;
    if (pop)               armed_d = 1'b0;
    else if (!uartReadReq) armed_d = 1'b1;
    ack_d     = pop;
    rd_data_d = pop ? mem[rd_ptr_q] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      push_q       <= 1'b0;
      framing_q    <= 1'b0;
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      armed_q      <= 1'b1;
      ack_q        <= 1'b0;
      rd_data_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= uartRx;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      push_q       <= push_d;
      framing_q    <= framing_d;
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      armed_q      <= armed_d;
      ack_q        <= ack_d;
      rd_data_q    <= rd_data_d;
      overrun_q    <= overrun_d;
    end
  end

  assign uartReadAck  = ack_q;
  assign uartReadData = rd_data_q;
  assign fifoCount    = count_q;
  assign overrun      = overrun_q;
  assign framingErr   = framing_q;
`ifdef UART_RX_PARITY_EN
  assign parityErr    = parity_err_q;
`else
  assign parityErr    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_responder.sv
// Directed bench for uart_rx_responder at 16 clocks per bit and a 4-entry FIFO.
// Define UART_RX_PARITY_EN here as well to exercise the parity frames.
module tb_uart_rx_responder;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uartRx = 1'b1;
  logic       uartReadReq = 1'b0;
  logic       uartReadAck;
  logic [7:0] uartReadData;
  logic [2:0] fifoCount;
  logic       overrun;
  logic       framingErr;
  logic       parityErr;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] last_data = 8'h00;

  uart_rx_responder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .uartRx(uartRx), .uartReadReq(uartReadReq),
    .uartReadAck(uartReadAck), .uartReadData(uartReadData), .fifoCount(fifoCount),
    .overrun(overrun), .framingErr(framingErr), .parityErr(parityErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (uartReadAck) begin
      ack_cnt   <= ack_cnt + 1;
      last_data <= uartReadData;
    end
    if (framingErr) fe_cnt <= fe_cnt + 1;
    if (parityErr)  pe_cnt <= pe_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic send_bit(input logic v);
    @(negedge clk);
    uartRx = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    logic par_v;
    par_v = (^d) ^ par_flip;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_v);
`endif
    send_bit(stop_v);
  endtask

  task automatic settle();
    @(negedge clk);
    uartRx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_read(output logic [7:0] d, output bit got);
    int a0;
    a0  = ack_cnt;
    got = 1'b0;
    @(negedge clk);
    uartReadReq = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (ack_cnt != a0) got = 1'b1;
    end
    d = last_data;
    uartReadReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (uartReadAck !== 1'b0)   begin failures++; $display("FAIL reset_ack got=%b exp=0", uartReadAck); end
    checks++; if (uartReadData !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", uartReadData); end
    checks++; if (fifoCount !== 3'd0)     begin failures++; $display("FAIL reset_count got=%0d exp=0", fifoCount); end
    checks++; if (overrun !== 1'b0)       begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (framingErr !== 1'b0)    begin failures++; $display("FAIL reset_framing got=%b exp=0", framingErr); end
    checks++; if (parityErr !== 1'b0)     begin failures++; $display("FAIL reset_parity got=%b exp=0", parityErr); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single();
    int a0, f0, p0;
    bit got;
    a0 = ack_cnt; f0 = fe_cnt; p0 = pe_cnt; got = 1'b0;
    @(negedge clk);
    uartReadReq = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (ack_cnt != a0) got = 1'b1;
    end
    uartReadReq = 1'b0;
    settle();
    checks++; if (!got) begin failures++; $display("FAIL single_ack_timeout got=0 exp=1"); end
    checks++; if (ack_cnt - a0 != 1) begin failures++; $display("FAIL single_ack_count got=%0d exp=1", ack_cnt - a0); end
    checks++; if (last_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", last_data); end
    checks++; if (fifoCount !== 3'd0) begin failures++; $display("FAIL single_count got=%0d exp=0", fifoCount); end
    checks++; if (fe_cnt != f0 || pe_cnt != p0 || overrun !== 1'b0) begin
      failures++; $display("FAIL single_flags fe=%0d pe=%0d ovr=%b exp=0/0/0", fe_cnt - f0, pe_cnt - p0, overrun);
    end
    $display("test_single data=%h", last_data);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    logic [7:0] d;
    bit got;
    int a0;
    exp_b[0] = 8'h01; exp_b[1] = 8'h80; exp_b[2] = 8'hFF;
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, 1'b0);
    settle();
    checks++; if (fifoCount !== 3'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", fifoCount); end
    for (int i = 0; i < 3; i++) begin
      do_read(d, got);
      checks++; if (!got || d !== exp_b[i]) begin failures++; $display("FAIL b2b_read%0d got=%h ack=%b exp=%h", i, d, got, exp_b[i]); end
      $display("test_back_to_back read%0d data=%h", i, d);
    end
    checks++; if (fifoCount !== 3'd0) begin failures++; $display("FAIL b2b_drained got=%0d exp=0", fifoCount); end
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    settle();
    a0 = ack_cnt;
    @(negedge clk);
    uartReadReq = 1'b1;
    repeat (10) @(negedge clk);
    uartReadReq = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ack_cnt - a0 != 1) begin failures++; $display("FAIL hold_ack_count got=%0d exp=1", ack_cnt - a0); end
    checks++; if (last_data !== 8'h12) begin failures++; $display("FAIL hold_data got=%h exp=12", last_data); end
    checks++; if (fifoCount !== 3'd1) begin failures++; $display("FAIL hold_count got=%0d exp=1", fifoCount); end
    do_read(d, got);
    checks++; if (!got || d !== 8'h34) begin failures++; $display("FAIL hold_drain got=%h ack=%b exp=34", d, got); end
    $display("test_back_to_back hold acks=%0d", ack_cnt - a0);
  endtask

  task automatic test_overrun();
    logic [7:0] exp_b [5];
    logic [7:0] d;
    bit got;
    exp_b[0] = 8'h10; exp_b[1] = 8'h20; exp_b[2] = 8'h30; exp_b[3] = 8'h40; exp_b[4] = 8'h50;
    for (int i = 0; i < 5; i++) send_frame(exp_b[i], 1'b1, 1'b0);
    settle();
    checks++; if (fifoCount !== 3'd4) begin failures++; $display("FAIL ovr_count got=%0d exp=4", fifoCount); end
    checks++; if (overrun !== 1'b1)   begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    for (int i = 0; i < 4; i++) begin
      do_read(d, got);
      checks++; if (!got || d !== exp_b[i]) begin failures++; $display("FAIL ovr_read%0d got=%h ack=%b exp=%h", i, d, got, exp_b[i]); end
      $display("test_overrun read%0d data=%h", i, d);
    end
    checks++; if (fifoCount !== 3'd0 || overrun !== 1'b1) begin
      failures++; $display("FAIL ovr_after count=%0d ovr=%b exp=0/1", fifoCount, overrun);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] frame;
    logic [7:0] d;
    bit got;
    frame = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(frame[i]);
    @(negedge clk);
    uartRx = frame[4];
    repeat (6) @(negedge clk);
    reset = 1'b0;
    uartRx = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (uartReadAck !== 1'b0 || uartReadData !== 8'h00 || fifoCount !== 3'd0 ||
                  overrun !== 1'b0 || framingErr !== 1'b0 || parityErr !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs ack=%b data=%h cnt=%0d ovr=%b fe=%b pe=%b exp=all zero",
               uartReadAck, uartReadData, fifoCount, overrun, framingErr, parityErr);
    end
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0);
    settle();
    checks++; if (fifoCount !== 3'd1) begin failures++; $display("FAIL midreset_count got=%0d exp=1", fifoCount); end
    do_read(d, got);
    checks++; if (!got || d !== 8'h5A) begin failures++; $display("FAIL midreset_data got=%h ack=%b exp=5a", d, got); end
    $display("test_reset_midframe data=%h", d);
  endtask

  task automatic test_glitch_framing();
    int f0;
    logic [7:0] d;
    bit got;
    f0 = fe_cnt;
    @(negedge clk);
    uartRx = 1'b0;
    repeat (4) @(negedge clk);
    uartRx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checks++; if (fifoCount !== 3'd0 || fe_cnt != f0) begin
      failures++; $display("FAIL glitch cnt=%0d fe=%0d exp=0/0", fifoCount, fe_cnt - f0);
    end
    $display("test_glitch count=%0d", fifoCount);
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    uartRx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checks++; if (fe_cnt - f0 != 1) begin failures++; $display("FAIL framing_pulses got=%0d exp=1", fe_cnt - f0); end
    checks++; if (fifoCount !== 3'd0) begin failures++; $display("FAIL framing_nopush got=%0d exp=0", fifoCount); end
    send_frame(8'h11, 1'b1, 1'b0);
    settle();
    do_read(d, got);
    checks++; if (!got || d !== 8'h11) begin failures++; $display("FAIL framing_recover got=%h ack=%b exp=11", d, got); end
    $display("test_framing pulses=%0d next=%h", fe_cnt - f0, d);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0;
    logic [7:0] d;
    bit got;
    p0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    settle();
    checks++; if (fifoCount !== 3'd1 || pe_cnt != p0) begin
      failures++; $display("FAIL parity_good cnt=%0d pe=%0d exp=1/0", fifoCount, pe_cnt - p0);
    end
    do_read(d, got);
    checks++; if (!got || d !== 8'h07) begin failures++; $display("FAIL parity_good_data got=%h exp=07", d); end
    send_frame(8'h07, 1'b1, 1'b1);
    settle();
    checks++; if (fifoCount !== 3'd0 || pe_cnt - p0 != 1) begin
      failures++; $display("FAIL parity_bad cnt=%0d pe=%0d exp=0/1", fifoCount, pe_cnt - p0);
    end
    $display("test_parity pulses=%0d", pe_cnt - p0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    test_glitch_framing();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
